puf_resp_collector: RTL and testbench
=====================================

PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

Interface
REQ-001 Parameter DEPTH, default 8, output FIFO depth in entries; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 fsm_rst  input  1  reset, asynchronous, active-high.
REQ-004 ps  input  2  sequencer present state: START=0, PUF1=1, PUF2=2, HALT=3.
REQ-005 puf1_counter  input  8  challenge index currently applied to PUF1.
REQ-006 puf2_counter  input  8  challenge index currently applied to PUF2.
REQ-007 resp_valid  input  1  one-cycle strobe: resp_bit holds a settled PUF response.
REQ-008 resp_bit  input  1  response bit of the PUF selected by ps.
REQ-009 out_ready  input  1  consumer can accept out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid FIFO head entry.
REQ-011 out_data  output  16  {puf_id[15], 0[14:8], resp_byte[7:0]}; puf_id 0=PUF1, 1=PUF2.
REQ-012 hd_count  output  9  Hamming distance accumulated between paired PUF1/PUF2 responses.
REQ-013 pair_count  output  9  number of PUF1/PUF2 pairs compared.
REQ-014 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 done  output  1  high while ps==HALT.

Function
REQ-016 Capture SHALL occur only when ps is PUF1 or PUF2 and resp_valid=1; resp_valid in START or HALT SHALL be ignored.
REQ-017 Each state visit SHALL capture at most one bit: after a capture, a taken flag blocks further captures until ps changes value.
REQ-018 The taken flag SHALL clear in the cycle after ps changes, so a visit whose strobe coincides with ps's first cycle is still captured.
REQ-019 A PUF1 capture SHALL shift resp_bit into the LSB of an 8-bit shift register sr1 and increment a 3-bit count c1; PUF2 captures do the same with sr2/c2.
REQ-020 When a capture makes c1 (or c2) wrap 7->0, the completed byte SHALL be pushed to the FIFO the same cycle with puf_id 0 (or 1); MSB = oldest bit.
REQ-021 A PUF1 capture SHALL store resp_bit and index puf1_counter in a pending register and set pend_valid.
REQ-022 A PUF2 capture with pend_valid=1 and puf2_counter equal to the pending index SHALL add (pending bit XOR resp_bit) to hd_count, add 1 to pair_count, and clear pend_valid.
REQ-023 A PUF2 capture with no matching pending entry SHALL update sr2/c2 only; hd_count and pair_count are unchanged.
REQ-024 hd_count and pair_count SHALL saturate at 256 (9'h100) and never wrap.
REQ-025 FIFO: DEPTH entries of 9 bits, show-ahead; out_valid=1 iff not empty; pop when out_valid && out_ready.
REQ-026 Push with FIFO full and no pop that cycle SHALL drop the byte and set overflow; simultaneous push and pop when full SHALL succeed.
REQ-027 Simultaneous push and pop when empty SHALL leave the FIFO empty-then-valid next cycle (no bypass; out_valid rises one cycle after push).
REQ-028 Transition HALT->START SHALL clear sr1, sr2, c1, c2, pend_valid, hd_count, pair_count and overflow; FIFO contents SHALL be retained.
REQ-029 Partial bytes (c != 0) SHALL NOT be flushed on HALT; they are discarded at the next HALT->START.
REQ-030 done SHALL be registered: high the cycle after ps becomes HALT, low the cycle after ps leaves HALT.

Reset
REQ-031 fsm_rst=1 SHALL immediately clear all registers: FIFO empty, out_valid=0, out_data=0, hd_count=0, pair_count=0, overflow=0, done=0, taken flag 0.
REQ-032 Reset asserted mid-byte or mid-pair SHALL discard all partial state; first capture after release starts a new byte at bit 0.

Verification
REQ-033 Eight PUF1 visits with bits 1,0,1,1,0,0,1,0, out_ready=1 -> one entry out_data=16'h00B2, out_valid high exactly one cycle.
REQ-034 Pairs (index n, PUF1 bit, PUF2 bit) for n=0..9 with bits differing on n=2,5,7 -> hd_count=3, pair_count=10.
REQ-035 Three resp_valid strobes within one PUF1 visit -> only the first is captured; c1 increments by 1.
REQ-036 out_ready=0, DEPTH=8, 72 bits from PUF1 (9 bytes) -> 8 entries held, overflow=1, 9th byte dropped; then out_ready=1 drains exactly 8 entries in order.
REQ-037 256 matched pairs all differing, then one more -> hd_count=pair_count=256 held; HALT->START -> both 0, overflow 0, FIFO entries unchanged.
REQ-038 fsm_rst pulsed asynchronously after 5 PUF2 bits -> all outputs 0 within same cycle; next 8 PUF2 bits produce one byte with puf_id=1.

Source files
------------

// File: rtl/puf_resp_collector.sv
// PUF response collector: packs PUF1/PUF2 response bits into bytes,
// queues them in a show-ahead FIFO and tracks PUF1/PUF2 Hamming distance.
// Ports:
//   clk, fsm_rst        clock, async active-high reset
//   ps                  sequencer state (START/PUF1/PUF2/HALT)
//   puf1/2_counter      challenge index applied to each PUF
//   resp_valid/bit      response strobe and bit
//   out_ready/valid     FIFO pop handshake, out_data = head entry
//   hd_count/pair_count Hamming distance and pairs compared
//   overflow            sticky byte-dropped flag
//   done                registered ps==HALT
module puf_resp_collector #(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        fsm_rst,
   input  logic [1:0]  ps,
   input  logic [7:0]  puf1_counter,
   input  logic [7:0]  puf2_counter,
   input  logic        resp_valid,
   input  logic        resp_bit,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic [8:0]  hd_count,
   output logic [8:0]  pair_count,
   output logic        overflow,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PUF1  = 2'd1,
      ST_PUF2  = 2'd2,
      ST_HALT  = 2'd3
   } ps_e;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [8:0] SAT = 9'h100;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   ps_e        ps_s;
   ps_e        ps_q;
   logic       taken_q, taken_d;
   logic [7:0] sr1_q, sr1_d;
   logic [7:0] sr2_q, sr2_d;
   logic [2:0] c1_q, c1_d;
   logic [2:0] c2_q, c2_d;
   logic       pbit_q, pbit_d;
   logic [7:0] pidx_q, pidx_d;
   logic       pval_q, pval_d;
   logic [8:0] hd_q, hd_d;
   logic [8:0] pair_q, pair_d;
   logic       ovf_q, ovf_d;
   logic       done_q, done_d;
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic [8:0] mem [DEPTH];

   logic       ps_chg;
   logic       cap_en;
   logic       cap1;
   logic       cap2;
   logic       match;
   logic       restart;
   logic       push;
   logic [8:0] push_data;
   logic       empty;
   logic       full;
   logic       pop;
   logic       wr_en;
   logic       drop;
   logic [8:0] head;

   assign ps_s = ps_e'(ps);
   assign ps_chg = (ps_s != ps_q);
   // A new visit re-arms capture in its first cycle, before
   // the taken flag has had a chance to clear.
   assign cap_en = resp_valid && (!taken_q || ps_chg);
   assign cap1 = cap_en && (ps_s == ST_PUF1);
   assign cap2 = cap_en && (ps_s == ST_PUF2);
   assign match = cap2 && pval_q && (puf2_counter == pidx_q);
   assign restart = (ps_q == ST_HALT) && (ps_s == ST_START);

   assign push = (cap1 && (c1_q == 3'd7)) ||
                 (cap2 && (c2_q == 3'd7));
   assign push_data = cap1 ? {1'b0, sr1_q[6:0], resp_bit}
                           : {1'b1, sr2_q[6:0], resp_bit};

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && out_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   assign head = mem[rd_q[AW-1:0]];
   assign out_valid = !empty;
   assign out_data = empty ? 16'd0 : {head[8], 7'd0, head[7:0]};
   assign hd_count = hd_q;
   assign pair_count = pair_q;
   assign overflow = ovf_q;
   assign done = done_q;

   always_comb begin
      taken_d = taken_q;
      sr1_d   = sr1_q;
      sr2_d   = sr2_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      pbit_d  = pbit_q;
      pidx_d  = pidx_q;
      pval_d  = pval_q;
      hd_d    = hd_q;
      pair_d  = pair_q;
      ovf_d   = ovf_q;
      done_d  = (ps_s == ST_HALT);
      wr_d    = wr_q;
      rd_d    = rd_q;

      if (cap1 || cap2) begin
         taken_d = 1'b1;
      end else if (ps_chg) begin
         taken_d = 1'b0;
      end

      if (cap1) begin
         sr1_d  = {sr1_q[6:0], resp_bit};
         c1_d   = c1_q + 3'd1;
         pbit_d = resp_bit;
         pidx_d = puf1_counter;
         pval_d = 1'b1;
      end

      if (cap2) begin
         sr2_d = {sr2_q[6:0], resp_bit};
         c2_d  = c2_q + 3'd1;
      end

      if (match) begin
         pval_d = 1'b0;
         if (hd_q != SAT) begin
            hd_d = hd_q + {8'd0, pbit_q ^ resp_bit};
         end
         if (pair_q != SAT) begin
            pair_d = pair_q + 9'd1;
         end
      end

      if (drop) begin
         ovf_d = 1'b1;
      end

      // Run restart discards statistics and partial bytes
      // but leaves queued bytes for the consumer.
      if (restart) begin
         sr1_d  = 8'd0;
         sr2_d  = 8'd0;
         c1_d   = 3'd0;
         c2_d   = 3'd0;
         pval_d = 1'b0;
         hd_d   = 9'd0;
         pair_d = 9'd0;
         ovf_d  = 1'b0;
      end

      if (wr_en) begin
         wr_d = wr_q + PTR_ONE;
      end
      if (pop) begin
         rd_d = rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge fsm_rst) begin
      if (fsm_rst) begin
         ps_q    <= ST_START;
         taken_q <= 1'b0;
         sr1_q   <= 8'd0;
         sr2_q   <= 8'd0;
         c1_q    <= 3'd0;
         c2_q    <= 3'd0;
         pbit_q  <= 1'b0;
         pidx_q  <= 8'd0;
         pval_q  <= 1'b0;
         hd_q    <= 9'd0;
         pair_q  <= 9'd0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         ps_q    <= ps_s;
         taken_q <= taken_d;
         sr1_q   <= sr1_d;
         sr2_q   <= sr2_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         pbit_q  <= pbit_d;
         pidx_q  <= pidx_d;
         pval_q  <= pval_d;
         hd_q    <= hd_d;
         pair_q  <= pair_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Directed bench for puf_resp_collector.
// Each task drives one scenario and checks its results inline.
module tb_puf_resp_collector;

   logic        clk;
   logic        fsm_rst;
   logic [1:0]  ps;
   logic [7:0]  puf1_counter;
   logic [7:0]  puf2_counter;
   logic        resp_valid;
   logic        resp_bit;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic [8:0]  hd_count;
   logic [8:0]  pair_count;
   logic        overflow;
   logic        done;

   int checks = 0;
   int passes = 0;

   puf_resp_collector #(.DEPTH(8)) dut (
      .clk          (clk),
      .fsm_rst      (fsm_rst),
      .ps           (ps),
      .puf1_counter (puf1_counter),
      .puf2_counter (puf2_counter),
      .resp_valid   (resp_valid),
      .resp_bit     (resp_bit),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .hd_count     (hd_count),
      .pair_count   (pair_count),
      .overflow     (overflow),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic visit(input logic [1:0] p, input logic b,
                        input logic [7:0] idx);
      ps = p;
      resp_valid = 1'b1;
      resp_bit = b;
      puf1_counter = idx;
      puf2_counter = idx;
      step();
      resp_valid = 1'b0;
      ps = 2'd0;
      step();
   endtask

   task automatic pair(input logic [7:0] idx, input logic b1,
                       input logic b2);
      ps = 2'd1;
      resp_valid = 1'b1;
      resp_bit = b1;
      puf1_counter = idx;
      step();
      ps = 2'd2;
      resp_bit = b2;
      puf2_counter = idx;
      step();
      ps = 2'd0;
      resp_valid = 1'b0;
      step();
   endtask

   task automatic halt_start();
      ps = 2'd3;
      step();
      step();
      ps = 2'd0;
      step();
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL rst_valid: got %b want 0", out_valid);
      else passes++;
      checks++;
      if (out_data !== 16'h0000)
         $display("FAIL rst_data: got %h want 0000", out_data);
      else passes++;
      checks++;
      if (hd_count !== 9'd0 || pair_count !== 9'd0)
         $display("FAIL rst_counts: got %0d/%0d want 0/0",
                  hd_count, pair_count);
      else passes++;
      checks++;
      if (overflow !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_flags: got ovf=%b done=%b want 0/0",
                  overflow, done);
      else passes++;
      step();
      step();
      fsm_rst = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL post_rst_valid: got %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_done();
      ps = 2'd3;
      checks++;
      if (done !== 1'b0)
         $display("FAIL done_early: got %b want 0", done);
      else passes++;
      step();
      checks++;
      if (done !== 1'b1)
         $display("FAIL done_rise: got %b want 1", done);
      else passes++;
      ps = 2'd0;
      step();
      checks++;
      if (done !== 1'b0)
         $display("FAIL done_fall: got %b want 0", done);
      else passes++;
   endtask

   task automatic test_byte();
      logic [7:0] bits;
      bits = 8'hB2;
      out_ready = 1'b1;
      for (int i = 7; i >= 1; i--) visit(2'd1, bits[i], 8'(7 - i));
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL byte_early: got %b want 0", out_valid);
      else passes++;
      ps = 2'd1;
      resp_valid = 1'b1;
      resp_bit = bits[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h00B2)
         $display("FAIL byte_out: got v=%b d=%h want v=1 d=00b2",
                  out_valid, out_data);
      else passes++;
      resp_valid = 1'b0;
      ps = 2'd0;
      step();
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL byte_one_cycle: got %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_pairs();
      logic b1;
      logic b2;
      halt_start();
      out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         b1 = n[0];
         b2 = b1 ^ ((n == 2) || (n == 5) || (n == 7));
         pair(8'(n), b1, b2);
      end
      checks++;
      if (hd_count !== 9'd3 || pair_count !== 9'd10)
         $display("FAIL pairs: got hd=%0d pc=%0d want 3/10",
                  hd_count, pair_count);
      else passes++;
      visit(2'd1, 1'b0, 8'd20);
      visit(2'd2, 1'b1, 8'd21);
      checks++;
      if (hd_count !== 9'd3 || pair_count !== 9'd10)
         $display("FAIL pair_nomatch: got hd=%0d pc=%0d want 3/10",
                  hd_count, pair_count);
      else passes++;
      visit(2'd2, 1'b1, 8'd20);
      checks++;
      if (hd_count !== 9'd4 || pair_count !== 9'd11)
         $display("FAIL pair_late: got hd=%0d pc=%0d want 4/11",
                  hd_count, pair_count);
      else passes++;
   endtask

   task automatic test_taken();
      halt_start();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL taken_empty: got %b want 0", out_valid);
      else passes++;
      ps = 2'd0;
      resp_valid = 1'b1;
      resp_bit = 1'b0;
      step();
      ps = 2'd1;
      resp_bit = 1'b1;
      step();
      resp_bit = 1'b0;
      step();
      step();
      resp_valid = 1'b0;
      ps = 2'd0;
      step();
      for (int i = 0; i < 6; i++) visit(2'd1, 1'b1, 8'(i));
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL taken_count: got %b want 0", out_valid);
      else passes++;
      visit(2'd1, 1'b1, 8'd9);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h00FF)
         $display("FAIL taken_byte: got v=%b d=%h want v=1 d=00ff",
                  out_valid, out_data);
      else passes++;
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_b [9];
      logic [7:0] v;
      halt_start();
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
         exp_b[k] = {4'(k), ~4'(k)};
      end
      for (int k = 0; k < 9; k++) begin
         v = exp_b[k];
         for (int i = 7; i >= 0; i--) visit(2'd1, v[i], 8'(i));
         if (k == 7) begin
            checks++;
            if (overflow !== 1'b0)
               $display("FAIL ovf_full: got %b want 0", overflow);
            else passes++;
         end
      end
      checks++;
      if (overflow !== 1'b1)
         $display("FAIL ovf_set: got %b want 1", overflow);
      else passes++;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== {8'h00, exp_b[k]})
            $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h",
                     k, out_valid, out_data, {8'h00, exp_b[k]});
         else passes++;
         step();
      end
      checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b1)
         $display("FAIL drain_end: got v=%b ovf=%b want 0/1",
                  out_valid, overflow);
      else passes++;
   endtask

   task automatic test_saturation();
      halt_start();
      out_ready = 1'b0;
      for (int k = 0; k < 256; k++) pair(8'(k), k[0], ~k[0]);
      checks++;
      if (hd_count !== 9'h100 || pair_count !== 9'h100)
         $display("FAIL sat_reach: got hd=%0d pc=%0d want 256/256",
                  hd_count, pair_count);
      else passes++;
      pair(8'd0, 1'b0, 1'b1);
      checks++;
      if (hd_count !== 9'h100 || pair_count !== 9'h100)
         $display("FAIL sat_hold: got hd=%0d pc=%0d want 256/256",
                  hd_count, pair_count);
      else passes++;
      checks++;
      if (overflow !== 1'b1)
         $display("FAIL sat_ovf: got %b want 1", overflow);
      else passes++;
      halt_start();
      checks++;
      if (hd_count !== 9'd0 || pair_count !== 9'd0 ||
          overflow !== 1'b0)
         $display("FAIL restart_clr: got hd=%0d pc=%0d ovf=%b want 0",
                  hd_count, pair_count, overflow);
      else passes++;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (out_valid !== 1'b1 ||
             out_data !== (k[0] ? 16'h80AA : 16'h0055))
            $display("FAIL keep_%0d: got v=%b d=%h want v=1 d=%h",
                     k, out_valid, out_data,
                     (k[0] ? 16'h80AA : 16'h0055));
         else passes++;
         step();
      end
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL keep_end: got %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_async_reset();
      logic [7:0] bits;
      bits = 8'h69;
      halt_start();
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) visit(2'd1, 1'b1, 8'(i));
      pair(8'd3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) visit(2'd2, 1'b1, 8'd50);
      checks++;
      if (out_valid !== 1'b1 || hd_count !== 9'd1 ||
          pair_count !== 9'd1)
         $display("FAIL pre_arst: got v=%b hd=%0d pc=%0d want 1/1/1",
                  out_valid, hd_count, pair_count);
      else passes++;
      #2;
      fsm_rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000)
         $display("FAIL arst_fifo: got v=%b d=%h want 0/0000",
                  out_valid, out_data);
      else passes++;
      checks++;
      if (hd_count !== 9'd0 || pair_count !== 9'd0 ||
          overflow !== 1'b0 || done !== 1'b0)
         $display("FAIL arst_stat: got hd=%0d pc=%0d ovf=%b done=%b",
                  hd_count, pair_count, overflow, done);
      else passes++;
      step();
      #2;
      fsm_rst = 1'b0;
      step();
      out_ready = 1'b1;
      for (int i = 7; i >= 1; i--) visit(2'd2, bits[i], 8'd60);
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL arst_partial: got %b want 0", out_valid);
      else passes++;
      ps = 2'd2;
      resp_valid = 1'b1;
      resp_bit = bits[0];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h8069)
         $display("FAIL arst_byte: got v=%b d=%h want v=1 d=8069",
                  out_valid, out_data);
      else passes++;
      resp_valid = 1'b0;
      ps = 2'd0;
      step();
   endtask

   initial begin
      fsm_rst = 1'b1;
      ps = 2'd0;
      puf1_counter = 8'd0;
      puf2_counter = 8'd0;
      resp_valid = 1'b0;
      resp_bit = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_done();
      test_byte();
      test_pairs();
      test_taken();
      test_overflow();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
